// File: rtl/rgb2grey_pkg.sv
// Shared types and constants for the RGB-to-grey front end.
// Pixel field layout, assembler states and row padding helper.
package rgb2grey_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PAD     = 1'b1
  } asm_state_t;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // BMP rows are padded to a multiple of 4 bytes
  function automatic int pad_bytes(
    input int width,
    input bit row_pad
  );
    if (!row_pad) return 0;
    return (4 - ((3 * width) % 4)) % 4;
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position tracker for a raster frame.
// Flags the last pixel of a row and of a frame at the current position.
module pixel_pos_counter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic eol,
  output logic eof
);

  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign eol = col == COL_LAST;
  assign eof = eol && row == ROW_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_byte_assembler.sv
// Byte stream to packed 24-bit pixel assembler with BMP row padding skip.
// Emits framed pixels (eol/eof) on a valid/ready interface.
import rgb2grey_pkg::*;

module rgb_byte_assembler #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter bit BGR_ORDER  = 1'b1,
  parameter bit ROW_PAD    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] m_rgb_pixel,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_eol,
  output logic        m_eof
);

  localparam int PAD_BYTES = pad_bytes(IMG_WIDTH, ROW_PAD);
  localparam logic [1:0] PAD_LAST =
    2'(PAD_BYTES == 0 ? 0 : PAD_BYTES - 1);

  asm_state_t  state;
  asm_state_t  state_next;
  logic [1:0]  byte_idx;
  logic [1:0]  pad_cnt;
  logic [7:0]  stage0;
  logic [7:0]  stage1;
  logic [23:0] px_new;
  logic        accept;
  logic        load;
  logic        pos_eol;
  logic        pos_eof;

  assign s_ready = !rst && (state == PAD || byte_idx != 2'd2
                   || !m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign load    = accept && state == COLLECT && byte_idx == 2'd2;

  always_comb begin
    px_new = '0;
    if (BGR_ORDER) begin
      px_new[R_MSB:R_LSB] = s_byte;
      px_new[G_MSB:G_LSB] = stage1;
      px_new[B_MSB:B_LSB] = stage0;
    end else begin
      px_new[R_MSB:R_LSB] = stage0;
      px_new[G_MSB:G_LSB] = stage1;
      px_new[B_MSB:B_LSB] = s_byte;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      COLLECT:
        if (load && pos_eol && PAD_BYTES != 0)
          state_next = PAD;
      PAD:
        if (accept && pad_cnt == PAD_LAST)
          state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx    <= '0;
      pad_cnt     <= '0;
      stage0      <= '0;
      stage1      <= '0;
      m_valid     <= 1'b0;
      m_rgb_pixel <= '0;
      m_eol       <= 1'b0;
      m_eof       <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (accept && state == PAD) begin
        pad_cnt <= pad_cnt == PAD_LAST ? 2'd0 : pad_cnt + 2'd1;
      end else if (accept) begin
        unique case (byte_idx)
          2'd0: begin
            stage0   <= s_byte;
            byte_idx <= 2'd1;
          end
          2'd1: begin
            stage1   <= s_byte;
            byte_idx <= 2'd2;
          end
          default: begin
            byte_idx    <= 2'd0;
            m_valid     <= 1'b1;
            m_rgb_pixel <= px_new;
            m_eol       <= pos_eol;
            m_eof       <= pos_eof;
          end
        endcase
      end
    end
  end

  pixel_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .advance(load),
    .eol    (pos_eol),
    .eof    (pos_eof)
  );

endmodule

// File: tb/tb_rgb_byte_assembler.sv
// Scoreboard bench for rgb_byte_assembler over four configurations.
// Stimulus pushes expected pixels; a negedge monitor pops on transfer.
module tb_rgb_byte_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_byte  [4];
  logic        s_valid [4];
  logic        s_ready [4];
  logic [23:0] m_px    [4];
  logic        m_valid [4];
  logic        m_ready [4];
  logic        m_eol   [4];
  logic        m_eof   [4];

  int total = 0;
  int bad   = 0;

  int wid  [4] = '{4, 4, 3, 5};
  int hgt  [4] = '{2, 2, 2, 3};
  int padn [4] = '{0, 0, 3, 1};
  bit bgr  [4] = '{1, 0, 1, 1};

  int col_m [4];
  int row_m [4];
  logic [25:0] exp_q [4][$];

  logic [25:0] ea;
  logic [25:0] eb;
  logic        e;
  bit          done;

  rgb_byte_assembler #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2),
    .BGR_ORDER(1), .ROW_PAD(1)
  ) u0 (
    .clk(clk), .rst(rst),
    .s_byte(s_byte[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .m_rgb_pixel(m_px[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_eol(m_eol[0]), .m_eof(m_eof[0])
  );

  rgb_byte_assembler #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2),
    .BGR_ORDER(0), .ROW_PAD(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .s_byte(s_byte[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .m_rgb_pixel(m_px[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_eol(m_eol[1]), .m_eof(m_eof[1])
  );

  rgb_byte_assembler #(
    .IMG_WIDTH(3), .IMG_HEIGHT(2),
    .BGR_ORDER(1), .ROW_PAD(1)
  ) u2 (
    .clk(clk), .rst(rst),
    .s_byte(s_byte[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .m_rgb_pixel(m_px[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_eol(m_eol[2]), .m_eof(m_eof[2])
  );

  rgb_byte_assembler #(
    .IMG_WIDTH(5), .IMG_HEIGHT(3),
    .BGR_ORDER(1), .ROW_PAD(1)
  ) u3 (
    .clk(clk), .rst(rst),
    .s_byte(s_byte[3]), .s_valid(s_valid[3]),
    .s_ready(s_ready[3]), .m_rgb_pixel(m_px[3]),
    .m_valid(m_valid[3]), .m_ready(m_ready[3]),
    .m_eol(m_eol[3]), .m_eof(m_eof[3])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push_px(input int d,
                         input logic [7:0] b0,
                         input logic [7:0] b1,
                         input logic [7:0] b2,
                         output logic eol);
    logic [23:0] px;
    logic f;
    px  = bgr[d] ? {b2, b1, b0} : {b0, b1, b2};
    eol = col_m[d] == wid[d] - 1;
    f   = eol && row_m[d] == hgt[d] - 1;
    exp_q[d].push_back({f, eol, px});
    if (eol) begin
      col_m[d] = 0;
      row_m[d] = f ? 0 : row_m[d] + 1;
    end else begin
      col_m[d]++;
    end
  endtask

  task automatic send(input int d, input logic [7:0] b,
                      input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_byte[d]  = b;
    s_valid[d] = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready[d]) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout dut%0d byte %0h", d, b);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid[d] = 1'b0;
  endtask

  task automatic send_px(input int d,
                         input logic [7:0] b0,
                         input logic [7:0] b1,
                         input logic [7:0] b2,
                         input bit do_pad,
                         input logic [7:0] padv,
                         input bit rnd);
    logic eol;
    push_px(d, b0, b1, b2, eol);
    send(d, b0, rnd ? $urandom_range(0, 2) : 0);
    send(d, b1, rnd ? $urandom_range(0, 2) : 0);
    send(d, b2, rnd ? $urandom_range(0, 2) : 0);
    if (eol && do_pad)
      repeat (padn[d])
        send(d, rnd ? 8'($urandom_range(0, 255)) : padv,
             rnd ? $urandom_range(0, 2) : 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (m_valid[d] === 1'b1 && m_ready[d]) begin
        if (exp_q[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected dut%0d: got %0h want none",
                   d, m_px[d]);
        end else begin
          chk($sformatf("sb_dut%0d", d),
              32'({m_eof[d], m_eol[d], m_px[d]}),
              32'(exp_q[d].pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      s_byte[d]  = '0;
      s_valid[d] = 1'b0;
      m_ready[d] = 1'b1;
      col_m[d]   = 0;
      row_m[d]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_valid", 32'(m_valid[d]), 0);
      chk("rst_pixel", 32'(m_px[d]), 0);
      chk("rst_flags", 32'({m_eol[d], m_eof[d]}), 0);
      chk("rst_sready", 32'(s_ready[d]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      chk("post_rst_sready", 32'(s_ready[d]), 1);
    @(posedge clk);
    #1;

    send_px(0, 8'h10, 8'h20, 8'h30, 1, 8'hEE, 0);
    chk("lat_valid_bgr", 32'(m_valid[0]), 1);
    chk("lat_pixel_bgr", 32'(m_px[0]), 32'h302010);
    send_px(1, 8'h10, 8'h20, 8'h30, 1, 8'hEE, 0);
    chk("lat_valid_rgb", 32'(m_valid[1]), 1);
    chk("lat_pixel_rgb", 32'(m_px[1]), 32'h102030);
    for (int k = 1; k < 12; k++) begin
      send_px(0, 8'(k), 8'(k + 64), 8'(k + 128), 1, 8'hEE, 0);
      send_px(1, 8'(k), 8'(k + 64), 8'(k + 128), 1, 8'hEE, 0);
    end

    for (int k = 0; k < 7; k++)
      send_px(2, 8'(k * 3), 8'(k * 3 + 1), 8'(k * 3 + 2),
              1, 8'hEE, 0);

    @(posedge clk);
    #1 m_ready[0] = 1'b0;
    push_px(0, 8'h01, 8'h02, 8'h03, e);
    ea = exp_q[0][$];
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    send(0, 8'h03, 0);
    push_px(0, 8'h04, 8'h05, 8'h06, e);
    eb = exp_q[0][$];
    send(0, 8'h04, 0);
    send(0, 8'h05, 0);
    s_byte[0]  = 8'h06;
    s_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sready", 32'(s_ready[0]), 0);
      chk("stall_valid", 32'(m_valid[0]), 1);
      chk("stall_hold",
          32'({m_eof[0], m_eol[0], m_px[0]}), 32'(ea));
    end
    @(posedge clk);
    #1 m_ready[0] = 1'b1;
    #1 chk("release_sready", 32'(s_ready[0]), 1);
    @(posedge clk);
    #1 s_valid[0] = 1'b0;
    chk("release_valid", 32'(m_valid[0]), 1);
    chk("release_load",
        32'({m_eof[0], m_eol[0], m_px[0]}), 32'(eb));
    @(posedge clk);
    #1 chk("valid_drop", 32'(m_valid[0]), 0);

    send_px(2, 8'h31, 8'h32, 8'h33, 0, 8'hEE, 0);
    send_px(2, 8'h41, 8'h42, 8'h43, 0, 8'hEE, 0);
    send(2, 8'hEE, 0);
    send(0, 8'hAA, 0);
    send(0, 8'hBB, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_drain0", 32'(exp_q[0].size()), 0);
    chk("pre_rst_drain2", 32'(exp_q[2].size()), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("mid_rst_valid", 32'(m_valid[d]), 0);
      chk("mid_rst_out",
          32'({m_eof[d], m_eol[d], m_px[d]}), 0);
      chk("mid_rst_sready", 32'(s_ready[d]), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      col_m[d] = 0;
      row_m[d] = 0;
    end
    send_px(0, 8'h01, 8'h02, 8'h03, 1, 8'hEE, 0);
    chk("rst_pix_d0", 32'({m_eol[0], m_px[0]}), 32'h030201);
    send_px(2, 8'h11, 8'h22, 8'h33, 1, 8'hEE, 0);
    chk("rst_pix_d2", 32'({m_eol[2], m_px[2]}), 32'h332211);

    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 45; k++)
          send_px(3, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  1, 8'hEE, 1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_ready[3] = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready[3] = 1'b1;

    for (int n = 0; n < 100; n++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0)
        break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++)
      chk($sformatf("drain_dut%0d", d),
          32'(exp_q[d].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_byte_assembler.md
# rgb_byte_assembler

Upstream feeder for the grey-conversion datapath. Accepts a raw byte stream (as read from a BMP pixel array or a UART/SPI link), reorders colour bytes, drops per-row BMP padding and emits one packed 24-bit pixel per transfer on a valid/ready interface. Tracks column/row position and flags end-of-row and end-of-frame, so the downstream greyscale stage needs no framing logic of its own.

## Interface
- IMG_WIDTH, 640, pixels per row (≥1)
- IMG_HEIGHT, 480, rows per frame (≥1)
- BGR_ORDER, 1, 1: incoming byte order B,G,R (BMP); 0: R,G,B
- ROW_PAD, 1, 1: each row is followed by pad bytes up to a 4-byte boundary; 0: no padding
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_byte  input  8  incoming data byte
- s_valid  input  1  s_byte valid
- s_ready  output  1  block accepts s_byte this cycle
- m_rgb_pixel  output  24  packed pixel: R [23:16], G [15:8], B [7:0]
- m_valid  output  1  m_rgb_pixel valid
- m_ready  input  1  downstream accepts pixel
- m_eol  output  1  qualifies m_valid: pixel is last in its row
- m_eof  output  1  qualifies m_valid: pixel is last in frame (m_eol also high)

## Operation
- Byte accepted when s_valid && s_ready; pixel transferred when m_valid && m_ready.
- State machine: COLLECT (byte_idx 0,1,2) and PAD (pad_cnt counting skipped bytes).
- COLLECT: byte_idx 0 and 1 go into staging registers; byte_idx 2 loads the output register together with both staged bytes, sets m_valid, eol/eof from current position, advances position.
- Byte mapping: BGR_ORDER=1 → bytes 0,1,2 = B,G,R; BGR_ORDER=0 → R,G,B.
- Pad count per row: PAD_BYTES = ROW_PAD ? (4 − (3·IMG_WIDTH mod 4)) mod 4 : 0 (compile-time constant). Width 640 → 0; width 641 → 1; width 642 → 2; width 643 → 3.
- After last pixel of a row: PAD_BYTES=0 → stay in COLLECT; otherwise → PAD, accept and discard exactly PAD_BYTES bytes, then → COLLECT. Padding also follows the last row of a frame.
- Position: col 0..IMG_WIDTH−1, row 0..IMG_HEIGHT−1; col wraps to 0 and row increments at end of row; both wrap to 0 after the eof pixel (next frame starts with no gap).
- s_ready = !rst && (state==PAD || byte_idx!=2 || !m_valid || m_ready). Combinational path m_ready → s_ready is intended.
- Output register holds value, m_eol and m_eof stable while m_valid && !m_ready.
- Simultaneous pixel drain and byte_idx-2 load: new pixel replaces old, m_valid stays 1.

## Timing
- Reset values: m_valid 0, m_rgb_pixel 24'h0, m_eol 0, m_eof 0, byte_idx 0, col/row 0, state COLLECT; s_ready 0 during rst, 1 in first cycle after.
- Latency: third byte accepted at edge N → m_valid high after edge N (visible cycle N+1).
- Throughput: one pixel per 3 accepted bytes; back-to-back bytes sustain full rate with m_ready held high.
- m_valid drops the cycle after transfer unless a new pixel loads in the same cycle.
- Reset mid-pixel or mid-pad: partial pixel and pad progress discarded, frame position returns to (0,0); no pixel emitted for discarded bytes.
- s_valid low cycles insert gaps without losing state.

## Structure
- Shared package rgb2grey_pkg: state enum (COLLECT, PAD), pixel field offsets (R_MSB/LSB, G, B), function pad_bytes(width, row_pad).
- One sub-module: pixel_pos_counter (col/row counters, eol/eof generation, advance input), reusable by downstream frame consumers.
- Byte staging, FSM and output register stay in the top module.

## Test plan
- IMG_WIDTH=4, HEIGHT=2, BGR_ORDER=1: bytes 0x10,0x20,0x30 → m_rgb_pixel 24'h302010 one cycle after third byte.
- BGR_ORDER=0, same bytes → 24'h102030; m_eol on pixel 4, m_eof on pixel 8, position wraps for pixel 9.
- IMG_WIDTH=3 (9 bytes/row, 3 pad): bytes 0xEE in pad slots never appear on output; 12 bytes consumed per row.
- m_ready held low after first pixel: s_ready drops when byte_idx=2; m_rgb_pixel, m_eol stable; releasing m_ready transfers pixel and accepts third byte in same cycle.
- rst asserted after 2 bytes of a pixel: no output, next 3 bytes form a pixel at position (0,0); all outputs 0 during rst.
- Random s_valid/m_ready gaps over 3 frames of 5×3: output sequence matches golden model exactly.
